// File: rtl/coredma_param_sync_fifo.sv
// -----------------------------------------------------------------------------
// coredma_param_sync_fifo
//
// Single-clock FIFO for the CoreDMA datapath. It wraps a small word array
// with pointer/flag control, an explicit occupancy counter and a two-stage
// registered read port.
//
// Optional feature macro: FIFO_PARITY_EN
//   defined   : each stored word carries an even-parity bit; PAR_ERR pulses
//               with RD_VALID when a popped word fails the check.
//   undefined : no parity storage or logic; PAR_ERR is tied low.
//
// Ports
//   CLK, ARST_N    rising-edge clock, asynchronous active-low reset
//   FLUSH          synchronous clear of pointers, count, flags and the read pipe
//   WR_EN/WR_DATA  push request and word
//   RD_EN          pop request
//   RD_DATA        registered read word (holds when nothing is popped)
//   RD_VALID       one-cycle pulse: RD_DATA holds a newly popped word
//   FULL/EMPTY     LEVEL == DEPTH / LEVEL == 0
//   ALMOST_FULL    LEVEL >= AFULL_LVL
//   ALMOST_EMPTY   LEVEL <= AEMPTY_LVL
//   LEVEL          occupancy 0..DEPTH
//   OVERFLOW       sticky: a write was rejected
//   UNDERFLOW      sticky: a read was rejected
//   PAR_ERR        parity mismatch on the popped word (parity build only)
//
// Handshake: a write is accepted when WR_EN is high and the FIFO is not
// full, or it is full but a read is accepted on the same edge. A read is
// accepted when RD_EN is high and the FIFO is not empty. Rejected requests
// have no effect other than setting the matching sticky flag. A read
// accepted at edge N shows up on RD_DATA/RD_VALID after edge N+1.
// -----------------------------------------------------------------------------
module coredma_param_sync_fifo #(
  parameter int WIDTH      = 50,
  parameter int DEPTH_LOG2 = 2,
  parameter int AFULL_LVL  = 3,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                  CLK,
  input  logic                  ARST_N,
  input  logic                  FLUSH,
  input  logic                  WR_EN,
  input  logic [WIDTH-1:0]      WR_DATA,
  input  logic                  RD_EN,
  output logic [WIDTH-1:0]      RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic                  PAR_ERR
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L  = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AFULL_L  = AFULL_LVL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AEMPTY_L = AEMPTY_LVL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = 1;

`ifdef FIFO_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  // Word array; deliberately not reset.
  logic [MW-1:0] mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  s1_valid_q, s1_valid_d;   // read stage 1: word captured
  logic [MW-1:0]         s1_word_q, s1_word_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic          full, empty, wr_acc, rd_acc, mem_we;
  logic [MW-1:0] wr_word;

  assign full   = (level_q == DEPTH_L);
  assign empty  = (level_q == '0);
  assign wr_acc = WR_EN && (!full || RD_EN);
  assign rd_acc = RD_EN && !empty;
  assign mem_we = wr_acc && !FLUSH;

  always_comb begin
`ifdef FIFO_PARITY_EN
    wr_word = {^WR_DATA, WR_DATA};
`else
    wr_word = WR_DATA;
`endif
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    s1_valid_d = 1'b0;
    s1_word_d  = s1_word_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (FLUSH) begin
      // Same as reset except RD_DATA, which keeps its last word.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
      if (WR_EN && !wr_acc) ovf_d = 1'b1;
      if (RD_EN && !rd_acc) udf_d = 1'b1;
      // The word is captured on the accepting edge, before a same-edge write
      // to a full FIFO can overwrite that slot, so the old word is returned.
      s1_valid_d = rd_acc;
      if (rd_acc) s1_word_d = mem_q[rd_ptr_q];
      rd_valid_d = s1_valid_q;
      if (s1_valid_q) rd_data_d = s1_word_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      s1_valid_q <= s1_valid_d;
      s1_word_q  <= s1_word_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

`ifdef FIFO_PARITY_EN
  logic par_err_q, par_err_d;

  // Even parity over {parity, data} must reduce to 0 for a clean word.
  always_comb begin
    par_err_d = 1'b0;
    if (!FLUSH) par_err_d = s1_valid_q && (^s1_word_q);
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) par_err_q <= 1'b0;
    else         par_err_q <= par_err_d;
  end

  assign PAR_ERR = par_err_q;
`else
  assign PAR_ERR = 1'b0;
`endif

  // Flags decode from the registered occupancy.
  assign FULL         = full;
  assign EMPTY        = empty;
  assign ALMOST_FULL  = (level_q >= AFULL_L);
  assign ALMOST_EMPTY = (level_q <= AEMPTY_L);
  assign LEVEL        = level_q;
  assign RD_DATA      = rd_data_q;
  assign RD_VALID     = rd_valid_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_coredma_param_sync_fifo.sv
module tb_coredma_param_sync_fifo;

  localparam int W      = 50;
  localparam int DL     = 2;
  localparam int DEPTH  = 4;
  localparam int AFL    = 3;
  localparam int AEL    = 1;
  localparam int HALF   = 5;
  localparam int PERIOD = 10;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          arst_n;
  logic          flush;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          full_o, empty_o, afull_o, aempty_o;
  logic [DL:0]   level_o;
  logic          ovf_o, udf_o, par_err;

  coredma_param_sync_fifo #(
    .WIDTH(W), .DEPTH_LOG2(DL), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
  ) dut (
    .CLK(clk), .ARST_N(arst_n), .FLUSH(flush),
    .WR_EN(wr_en), .WR_DATA(wr_data), .RD_EN(rd_en),
    .RD_DATA(rd_data), .RD_VALID(rd_valid),
    .FULL(full_o), .EMPTY(empty_o), .ALMOST_FULL(afull_o), .ALMOST_EMPTY(aempty_o),
    .LEVEL(level_o), .OVERFLOW(ovf_o), .UNDERFLOW(udf_o), .PAR_ERR(par_err)
  );

  initial begin
    clk = 1'b0;
    forever #HALF clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];    // expected popped words, in order
  longint       exp_t[$];    // edge time after which each word must be visible
  bit           exp_pe[$];   // expected PAR_ERR with each word

  // Reference model: FIFO contents as a plain queue plus sticky flags.
  logic [W-1:0] mq[$];
  bit           mq_bad[$];
  bit           m_ovf, m_udf, rd_last;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_flags();
    int n;
    n = mq.size();
    chk("level",        64'(level_o),  64'(n));
    chk("full",         64'(full_o),   64'(n == DEPTH));
    chk("empty",        64'(empty_o),  64'(n == 0));
    chk("almost_full",  64'(afull_o),  64'(n >= AFL));
    chk("almost_empty", 64'(aempty_o), 64'(n <= AEL));
    chk("overflow",     64'(ovf_o),    64'(m_ovf));
    chk("underflow",    64'(udf_o),    64'(m_udf));
  endtask

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit fl, input bit we, input bit re, input logic [W-1:0] wd);
    bit wa, ra, fm, em;
    flush = fl; wr_en = we; rd_en = re; wr_data = wd;
    @(posedge clk);
    if (fl) begin
      // A read accepted on the previous edge never reaches the output.
      if (rd_last) begin
        void'(exp_q.pop_back()); void'(exp_t.pop_back()); void'(exp_pe.pop_back());
      end
      mq.delete(); mq_bad.delete();
      m_ovf = 0; m_udf = 0; rd_last = 0;
    end else begin
      fm = (mq.size() == DEPTH);
      em = (mq.size() == 0);
      wa = we && (!fm || re);
      ra = re && !em;
      if (ra) begin
        exp_q.push_back(mq.pop_front());
        exp_pe.push_back(mq_bad.pop_front());
        exp_t.push_back($time + PERIOD);
      end
      if (wa) begin
        mq.push_back(wd);
        mq_bad.push_back(1'b0);
      end
      if (we && !wa) m_ovf = 1;
      if (re && !ra) m_udf = 1;
      rd_last = ra;
    end
    #1 chk_flags();
  endtask

  task automatic reset_now();
    arst_n = 1'b0;
    #1;
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_rd_data",  64'(rd_data),  64'(0));
    mq.delete(); mq_bad.delete();
    exp_q.delete(); exp_t.delete(); exp_pe.delete();
    m_ovf = 0; m_udf = 0; rd_last = 0;
    chk_flags();
    flush = 0; wr_en = 0; rd_en = 0;
    @(posedge clk);
    #1 arst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] last_data = '0;

  always @(negedge clk) begin
    if (!arst_n) begin
      chk("mon_rst_valid", 64'(rd_valid), 64'(0));
      last_data = '0;
    end else if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rd_valid: got data %0h expected no pop at %0t", rd_data, $time);
      end else begin
        logic [W-1:0] d;
        longint t;
        bit pe;
        d = exp_q.pop_front(); t = exp_t.pop_front(); pe = exp_pe.pop_front();
        chk("rd_data",    64'(rd_data), 64'(d));
        chk("rd_latency", 64'($time - HALF), 64'(t));
        chk("par_err",    64'(par_err), 64'(pe));
      end
      last_data = rd_data;
    end else begin
      chk("rd_valid_known", 64'(rd_valid), 64'(0));
      chk("rd_data_hold",   64'(rd_data),  64'(last_data));
      chk("par_err_idle",   64'(par_err),  64'(0));
      while (exp_t.size() > 0 && exp_t[0] + HALF <= $time) begin
        checks++; errors++;
        $display("FAIL missing_rd_valid: got no pop expected data %0h at %0t", exp_q[0], $time);
        void'(exp_q.pop_front()); void'(exp_t.pop_front()); void'(exp_pe.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    arst_n = 1'b0; flush = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    m_ovf = 0; m_udf = 0; rd_last = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_valid", 64'(rd_valid), 64'(0));
    chk("reset_rd_data",  64'(rd_data),  64'(0));
    chk("reset_par_err",  64'(par_err),  64'(0));
    chk_flags();
    arst_n = 1'b1;

    // Fill with 1..4, then one write too many.
    for (int i = 1; i <= 4; i++) step(0, 1, 0, W'(i));
    step(0, 1, 0, W'(5));
    // Drain, then one read too many.
    repeat (4) step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    repeat (2) step(0, 0, 0, '0);

    // Continuous read+write from level 2; pointers wrap.
    step(1, 0, 0, '0);
    step(0, 1, 0, rnd());
    step(0, 1, 0, rnd());
    repeat (10) step(0, 1, 1, rnd());
    repeat (2) step(0, 0, 0, '0);

    // Full with read+write, drain, then empty with read+write.
    step(1, 0, 0, '0);
    repeat (4) step(0, 1, 0, rnd());
    step(0, 1, 1, rnd());
    step(0, 1, 1, rnd());
    repeat (4) step(0, 0, 1, '0);
    step(0, 1, 1, rnd());
    repeat (2) step(0, 0, 0, '0);

    // Flush at level 3 with a write, and with a read in flight.
    step(1, 0, 0, '0);
    repeat (3) step(0, 1, 0, rnd());
    step(0, 0, 1, '0);
    step(1, 1, 0, rnd());
    repeat (2) step(0, 0, 0, '0);

    // Reset while a read is in flight, and while RD_VALID is high.
    repeat (3) step(0, 1, 0, rnd());
    step(0, 0, 1, '0);
    reset_now();
    repeat (3) step(0, 1, 0, rnd());
    step(0, 0, 1, '0);
    step(0, 0, 0, '0);
    reset_now();

`ifdef FIFO_PARITY_EN
    // Corrupt one stored bit of the word at address 0.
    begin
      logic [W-1:0] tmp;
      step(1, 0, 0, '0);
      step(0, 1, 0, rnd());
      step(0, 1, 0, rnd());
      dut.mem_q[0][3] = ~dut.mem_q[0][3];
      tmp = mq[0]; tmp[3] = ~tmp[3]; mq[0] = tmp;
      mq_bad[0] = 1'b1;
      step(0, 0, 1, '0);
      step(0, 0, 1, '0);
      repeat (2) step(0, 0, 0, '0);
    end
`endif

    // Randomized traffic with varying write/read bias and rare flushes.
    for (int p = 0; p < 3; p++) begin
      repeat (500) begin
        int wp;
        wp = 30 + 20 * p;
        step($urandom_range(0, 79) == 0,
             $urandom_range(0, 99) < wp,
             $urandom_range(0, 99) < 50,
             rnd());
      end
    end

    repeat (4) step(0, 0, 0, '0);
    chk("pending_reads", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
